// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RISC-V main controller.
// Imported by the controller and its memory-port interface users.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I, OP_LD, OP_SD, OP_BEQ: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Shared memory port between the controller (master) and the memory (slave):
// request/ready handshake plus write and address-select qualifiers.
interface riscv_multicycle_ctrl_if;

    logic mem_req;
    logic mem_we;
    logic mem_iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_iord,
        output mem_ready
    );

endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle main control FSM: fetch/decode/execute/memory/writeback over one memory port,
// with a memory-wait timeout. Optional retired-instruction counter: RISCV_CTRL_INSTRET_EN.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                opcode,
    input  logic                      zero,
    riscv_multicycle_ctrl_if.master   bus,
    output logic                      IRWrite,
    output logic                      PCWrite,
    output logic                      PCSrc,
    output logic                      RegWrite,
    output logic                      MemtoReg,
    output logic                      ALUSrc,
    output logic                      MemRead,
    output logic                      MemWrite,
    output logic [1:0]                ALUOp,
    output logic                      illegal_instr,
    output logic                      err_timeout,
    output logic [CNT_W-1:0]          instret
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    // Set while reset is sampled and for one cycle after, so the port stays quiet.
    logic          idle_q, idle_d;
    logic          wait_expired;

    assign wait_expired = (MEM_TIMEOUT != 0) && (32'(tmo_q) == MEM_TIMEOUT - 1);

    always_comb begin
        state_d          = state_q;
        tmo_d            = '0;
        idle_d           = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_iord     = 1'b0;
        IRWrite          = 1'b0;
        PCWrite          = 1'b0;
        PCSrc            = 1'b0;
        RegWrite         = 1'b0;
        MemtoReg         = 1'b0;
        ALUSrc           = 1'b0;
        MemRead          = 1'b0;
        MemWrite         = 1'b0;
        ALUOp            = ALUOP_ADD;
        illegal_instr    = 1'b0;
        err_timeout      = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (!idle_q) begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = DECODE;
                    end else if (wait_expired) begin
                        err_timeout = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            DECODE: begin
                if (is_legal_op(opcode)) begin
                    state_d = EXEC;
                end else begin
                    illegal_instr = 1'b1;
                    state_d       = FETCH;
                end
            end
            EXEC: begin
                case (opcode)
                    OP_R: begin
                        ALUOp   = ALUOP_FUNCT;
                        state_d = WB;
                    end
                    OP_I: begin
                        ALUOp   = ALUOP_FUNCT;
                        ALUSrc  = 1'b1;
                        state_d = WB;
                    end
                    OP_LD, OP_SD: begin
                        ALUSrc  = 1'b1;
                        state_d = MEM;
                    end
                    OP_BEQ: begin
                        ALUOp   = ALUOP_SUB;
                        PCWrite = zero;
                        PCSrc   = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_iord = 1'b1;
                ALUSrc       = 1'b1;
                if (opcode == OP_SD) begin
                    bus.mem_we = 1'b1;
                    MemWrite   = 1'b1;
                end else begin
                    MemRead = 1'b1;
                end
                if (bus.mem_ready) begin
                    state_d = (opcode == OP_SD) ? FETCH : WB;
                end else if (wait_expired) begin
                    err_timeout = 1'b1;
                    state_d     = FETCH;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WB: begin
                RegWrite = 1'b1;
                MemtoReg = (opcode == OP_LD);
                ALUOp    = (opcode == OP_LD) ? ALUOP_ADD : ALUOP_FUNCT;
                ALUSrc   = (opcode != OP_R);
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            tmo_q   <= '0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            idle_q  <= idle_d;
        end
    end

`ifdef RISCV_CTRL_INSTRET_EN
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    always_comb begin
        retire = (state_q == WB)
               || ((state_q == EXEC) && (opcode == OP_BEQ))
               || ((state_q == MEM) && (opcode == OP_SD) && bus.mem_ready);
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: a per-instruction schedule model expands each
// instruction into expected per-cycle control vectors, which are compared against the DUT.
module tb_riscv_multicycle_ctrl;

    localparam int unsigned MT = 4;
    localparam int unsigned CW = 32;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       illegal;
        logic       err_timeout;
    } ctl_t;

    typedef struct {
        ctl_t       exp;
        logic       rdy;
        logic [6:0] op;
        logic       z;
        logic       ret;
    } step_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode;
    logic          zero;
    logic          IRWrite, PCWrite, PCSrc, RegWrite, MemtoReg, ALUSrc, MemRead, MemWrite;
    logic [1:0]    ALUOp;
    logic          illegal_instr, err_timeout;
    logic [CW-1:0] instret;

    riscv_multicycle_ctrl_if bus ();

    riscv_multicycle_ctrl #(
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .bus           (bus),
        .IRWrite       (IRWrite),
        .PCWrite       (PCWrite),
        .PCSrc         (PCSrc),
        .RegWrite      (RegWrite),
        .MemtoReg      (MemtoReg),
        .ALUSrc        (ALUSrc),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .ALUOp         (ALUOp),
        .illegal_instr (illegal_instr),
        .err_timeout   (err_timeout),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    ctl_t obs;
    assign obs = {bus.mem_req, bus.mem_we, bus.mem_iord, IRWrite, PCWrite, PCSrc, RegWrite,
                  MemtoReg, ALUSrc, MemRead, MemWrite, ALUOp, illegal_instr, err_timeout};

    step_t q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    ret_cnt = 0;
    int    step_no = 0;

    function automatic logic legal(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011)
            || (op == 7'b0100011) || (op == 7'b1100011);
    endfunction

    function automatic logic [CW-1:0] exp_instret();
`ifdef RISCV_CTRL_INSTRET_EN
        return CW'(ret_cnt);
`else
        return '0;
`endif
    endfunction

    task automatic add(input ctl_t e, input logic rdy, input logic [6:0] op, input logic z,
                       input logic ret);
        step_t s;
        s.exp = e;
        s.rdy = rdy;
        s.op  = op;
        s.z   = z;
        s.ret = ret;
        q.push_back(s);
    endtask

    // One memory access: w wait cycles then ready, unless the timeout fires first.
    task automatic mem_phase(input ctl_t base, input ctl_t done, input int w, input logic fetch,
                             input logic [6:0] op, input logic ret, output bit ok);
        ctl_t e;
        logic [6:0] o;
        ok = 0;
        for (int c = 0; c < 64; c++) begin
            o = fetch ? 7'($urandom) : op;
            if (c == w) begin
                e = ctl_t'(base | done);
                add(e, 1'b1, o, 1'($urandom), ret);
                ok = 1;
                return;
            end
            if (c == int'(MT) - 1) begin
                e = base;
                e.err_timeout = 1'b1;
                add(e, 1'b0, o, 1'($urandom), 1'b0);
                return;
            end
            add(base, 1'b0, o, 1'($urandom), 1'b0);
        end
    endtask

    task automatic build(input logic [6:0] op, input logic z, input int wf, input int wd);
        ctl_t f, d, e, n;
        bit ok;
        logic is_ld;
        f = '0; f.mem_req = 1'b1;
        d = '0; d.ir_write = 1'b1; d.pc_write = 1'b1;
        n = '0;
        mem_phase(f, d, wf, 1'b1, op, 1'b0, ok);
        if (!ok) return;
        if (!legal(op)) begin
            e = '0; e.illegal = 1'b1;
            add(e, 1'($urandom), op, 1'($urandom), 1'b0);
            return;
        end
        add(n, 1'($urandom), op, 1'($urandom), 1'b0);
        is_ld = (op == 7'b0000011);
        e = '0;
        if (op == 7'b1100011) begin
            e.alu_op = 2'b01; e.pc_write = z; e.pc_src = 1'b1;
            add(e, 1'($urandom), op, z, 1'b1);
        end else if (op == 7'b0110011 || op == 7'b0010011) begin
            e.alu_op = 2'b10; e.alu_src = (op == 7'b0010011);
            add(e, 1'($urandom), op, 1'($urandom), 1'b0);
            e.reg_write = 1'b1;
            add(e, 1'($urandom), op, 1'($urandom), 1'b1);
        end else begin
            e.alu_op = 2'b00; e.alu_src = 1'b1;
            add(e, 1'($urandom), op, 1'($urandom), 1'b0);
            f = e; f.mem_req = 1'b1; f.mem_iord = 1'b1;
            f.mem_we = !is_ld; f.mem_write = !is_ld; f.mem_read = is_ld;
            mem_phase(f, n, wd, 1'b0, op, !is_ld, ok);
            if (ok && is_ld) begin
                e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                add(e, 1'($urandom), op, 1'($urandom), 1'b1);
            end
        end
    endtask

    task automatic check_ctl(input string tag, input ctl_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_ret(input string tag);
        checks++;
        assert (instret === exp_instret()) else begin
            errors++;
            $error("FAIL %s step=%0d instret observed=%0d expected=%0d", tag, step_no, instret,
                   exp_instret());
        end
    endtask

    task automatic run_queue(input int max_steps);
        step_t s;
        for (int i = 0; i < max_steps && q.size() > 0; i++) begin
            s = q.pop_front();
            @(negedge clk);
            opcode        = s.op;
            zero          = s.z;
            bus.mem_ready = s.rdy;
            #1;
            step_no++;
            check_ctl("ctl", s.exp);
            check_ret("instret");
            if (s.ret) ret_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        ret_cnt = 0;
        check_ctl("reset_hold", '0);
        check_ret("reset_instret");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_ctl("reset_release", '0);
    endtask

    logic [6:0] ops [5];
    logic [6:0] op_r;
    ctl_t       e_mem;

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        reset = 1'b1;
        opcode = '0;
        zero = 1'b0;
        bus.mem_ready = 1'b0;
        do_reset();

        // Directed cases
        build(7'b0110011, 1'b0, 0, 0);
        build(7'b0000011, 1'b0, 2, 0);
        build(7'b1100011, 1'b1, 0, 0);
        build(7'b1100011, 1'b0, 0, 0);
        build(7'b1111111, 1'b0, 0, 0);
        build(7'b0100011, 1'b0, 0, 10);
        build(7'b0010011, 1'b0, 3, 0);
        build(7'b0100011, 1'b0, 1, 3);
        build(7'b0000011, 1'b0, 7, 0);
        build(7'b0110011, 1'b0, 0, 0);
        run_queue(1000);

        // Reset while a load waits in MEM
        build(7'b0000011, 1'b0, 0, 10);
        run_queue(4);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        opcode = 7'b0000011;
        #1;
        e_mem = '0;
        e_mem.mem_req = 1'b1; e_mem.mem_iord = 1'b1; e_mem.alu_src = 1'b1; e_mem.mem_read = 1'b1;
        check_ctl("mem_before_reset", e_mem);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        ret_cnt = 0;
        check_ctl("late_ready_ignored", '0);
        check_ret("mid_reset_instret");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_ctl("release_quiet", '0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        e_mem = '0;
        e_mem.mem_req = 1'b1;
        check_ctl("refetch_after_reset", e_mem);
        do_reset();

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) op_r = 7'($urandom);
            else op_r = ops[$urandom_range(0, 4)];
            build(op_r, 1'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end
        run_queue(5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
